track_tile_update_arbiter: RTL and testbench

- Shares the write port of the track tile-map RAM (256 entries × 4-bit tile type, addressed {tile_row[3:0], tile_col[3:0]}) between NUM_REQ game-logic requesters, such as item-box respawn and hazard placement.
- Accepted updates are buffered in a small FIFO.
- The FIFO is drained into the RAM only during vertical blanking, so the renderer never sees a tile change mid-frame.
- Sits between game logic and the tile-map RAM's write side, next to the pixel renderer.

---
 rtl/track_tile_update_arbiter.sv | 183 ++++++++++++++++++
 tb/tb_track_tile_update_arbiter.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/track_tile_update_arbiter.sv
// Round-robin arbiter collecting tile-map updates from game logic into a small FIFO,
// drained into the tile-map RAM write port only while the display is in vertical blanking.
module track_tile_update_arbiter #(
  parameter int NUM_REQ    = 2,
  parameter int FIFO_DEPTH = 4,
  parameter int ADDR_W     = 8,
  parameter int TILE_W     = 4,
  parameter int V_ACTIVE   = 720
) (
  input  logic                          clk_in,
  input  logic                          rst_in,
  input  logic [10:0]                   hcount_in,
  input  logic [9:0]                    vcount_in,
  input  logic [NUM_REQ-1:0]            req_valid_in,
  input  logic [NUM_REQ*ADDR_W-1:0]     req_addr_in,
  input  logic [NUM_REQ*TILE_W-1:0]     req_tile_in,
  output logic [NUM_REQ-1:0]            req_ready_out,
  output logic                          wr_en_out,
  output logic [ADDR_W-1:0]             wr_addr_out,
  output logic [TILE_W-1:0]             wr_data_out,
  output logic [$clog2(FIFO_DEPTH):0]   pending_out,
  output logic                          frame_flush_out
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int RW = $clog2(NUM_REQ);
  localparam int EW = ADDR_W + TILE_W;

  typedef enum logic [0:0] {IDLE, DRAIN} state_t;

  state_t          state_r;
  state_t          state_nxt_s;
  logic [CW-1:0]   count_r;
  logic [PW-1:0]   wr_ptr_r;
  logic [PW-1:0]   rd_ptr_r;
  logic [RW-1:0]   rr_ptr_r;
  logic [EW-1:0]   mem_r [FIFO_DEPTH];
  logic            in_blank_s;
  logic            space_s;
  logic [NUM_REQ-1:0] grant_s;
  logic [RW-1:0]   grant_idx_s;
  logic [RW:0]     search_s;
  logic            push_s;
  logic            pop_s;
  logic [EW-1:0]   push_entry_s;
  logic            blank_r;
  logic            zero_r;
  logic            wr_en_r;
  logic [ADDR_W-1:0] wr_addr_r;
  logic [TILE_W-1:0] wr_data_r;
  logic            hcount_unused_s;

  assign hcount_unused_s = ^hcount_in;

  assign in_blank_s = (vcount_in >= 10'(V_ACTIVE));
  // No full-bypass: space comes from the registered count only.
  assign space_s    = (count_r < CW'(FIFO_DEPTH));

  // Round-robin search starting at rr_ptr_r, wrapping modulo NUM_REQ
  always_comb begin
    grant_s     = '0;
    grant_idx_s = '0;
    push_s      = 1'b0;
    search_s    = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      search_s = {1'b0, rr_ptr_r} + (RW+1)'(k);
      if (search_s >= (RW+1)'(NUM_REQ)) begin
        search_s = search_s - (RW+1)'(NUM_REQ);
      end else begin
        search_s = search_s;
      end
      if (space_s && !push_s && req_valid_in[search_s[RW-1:0]]) begin
        grant_s[search_s[RW-1:0]] = 1'b1;
        grant_idx_s               = search_s[RW-1:0];
        push_s                    = 1'b1;
      end else begin
        push_s = push_s;
      end
    end
  end

  assign req_ready_out = grant_s;
  assign push_entry_s  = {req_addr_in[grant_idx_s*ADDR_W +: ADDR_W],
                          req_tile_in[grant_idx_s*TILE_W +: TILE_W]};

  // Drain FSM next-state and pop decision
  always_comb begin
    state_nxt_s = state_r;
    pop_s       = 1'b0;
    case (state_r)
      IDLE, DRAIN: begin
        if (in_blank_s && (count_r != CW'(0))) begin
          pop_s = 1'b1;
          if ((count_r == CW'(1)) && !push_s) begin
            state_nxt_s = IDLE;
          end else begin
            state_nxt_s = DRAIN;
          end
        end else begin
          state_nxt_s = IDLE;
        end
      end
      default: begin
        state_nxt_s = IDLE;
        pop_s       = 1'b0;
      end
    endcase
  end

  // FSM state, FIFO pointers, occupancy and round-robin pointer
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_r  <= IDLE;
      count_r  <= '0;
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      rr_ptr_r <= '0;
    end else begin
      state_r <= state_nxt_s;
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PW'(1);
        if (grant_idx_s == RW'(NUM_REQ - 1)) begin
          rr_ptr_r <= '0;
        end else begin
          rr_ptr_r <= grant_idx_s + RW'(1);
        end
      end else begin
        wr_ptr_r <= wr_ptr_r;
        rr_ptr_r <= rr_ptr_r;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PW'(1);
      end else begin
        rd_ptr_r <= rd_ptr_r;
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // FIFO storage; contents are meaningless outside the pointer window, so no reset
  always_ff @(posedge clk_in) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= push_entry_s;
    end else begin
      mem_r[wr_ptr_r] <= mem_r[wr_ptr_r];
    end
  end

  // Registered RAM write port and blanking-end history
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      wr_en_r   <= 1'b0;
      wr_addr_r <= '0;
      wr_data_r <= '0;
      blank_r   <= 1'b0;
      zero_r    <= 1'b0;
    end else begin
      wr_en_r <= pop_s;
      if (pop_s) begin
        wr_addr_r <= mem_r[rd_ptr_r][EW-1:TILE_W];
        wr_data_r <= mem_r[rd_ptr_r][TILE_W-1:0];
      end else begin
        wr_addr_r <= wr_addr_r;
        wr_data_r <= wr_data_r;
      end
      blank_r <= in_blank_s;
      zero_r  <= (count_r == CW'(0));
    end
  end

  assign wr_en_out       = wr_en_r;
  assign wr_addr_out     = wr_addr_r;
  assign wr_data_out     = wr_data_r;
  assign pending_out     = count_r;
  // Blanking just ended (previous cycle blank, this vcount not) with nothing queued then.
  assign frame_flush_out = blank_r & ~in_blank_s & zero_r;

endmodule

// File: tb/tb_track_tile_update_arbiter.sv
// Scoreboard bench for track_tile_update_arbiter: a behavioural queue model predicts
// grants, occupancy, write timing/order and flush pulses every cycle.
module tb_track_tile_update_arbiter;
  localparam int NR = 2;
  localparam int FD = 4;
  localparam int AW = 8;
  localparam int TW = 4;
  localparam int VA = 720;

  logic              clk_in = 1'b0;
  logic              rst_in;
  logic [10:0]       hcount_in;
  logic [9:0]        vcount_in;
  logic [NR-1:0]     req_valid_in;
  logic [NR*AW-1:0]  req_addr_in;
  logic [NR*TW-1:0]  req_tile_in;
  logic [NR-1:0]     req_ready_out;
  logic              wr_en_out;
  logic [AW-1:0]     wr_addr_out;
  logic [TW-1:0]     wr_data_out;
  logic [2:0]        pending_out;
  logic              frame_flush_out;

  track_tile_update_arbiter #(.NUM_REQ(NR), .FIFO_DEPTH(FD), .ADDR_W(AW), .TILE_W(TW), .V_ACTIVE(VA)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .hcount_in(hcount_in), .vcount_in(vcount_in),
    .req_valid_in(req_valid_in), .req_addr_in(req_addr_in), .req_tile_in(req_tile_in),
    .req_ready_out(req_ready_out), .wr_en_out(wr_en_out), .wr_addr_out(wr_addr_out),
    .wr_data_out(wr_data_out), .pending_out(pending_out), .frame_flush_out(frame_flush_out)
  );

  always #5 clk_in = ~clk_in;

  int n_checks = 0;
  int n_fail   = 0;

  logic [11:0] m_q[$];
  int          m_rr;
  logic        m_blank_prev, m_zero_prev, m_out_v;
  logic [11:0] m_out;
  logic [1:0]  m_grant, obs_ready;
  logic [7:0]  a0, a1;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic m_reset();
    m_q.delete();
    m_rr = 0; m_blank_prev = 1'b0; m_zero_prev = 1'b0; m_out_v = 1'b0; m_out = '0;
    m_grant = '0;
  endtask

  task automatic set_req(input int i, input logic v, input logic [7:0] a, input logic [3:0] t);
    req_valid_in[i]        = v;
    req_addr_in[i*AW +: AW] = a;
    req_tile_in[i*TW +: TW] = t;
  endtask

  // One clock: compare at negedge, advance the model for the coming edge, return 1ns past it.
  task automatic cycle();
    logic       blank;
    logic [1:0] g;
    int         idx;
    @(negedge clk_in);
    blank = (vcount_in >= 10'(VA));
    g = '0;
    if (m_q.size() < FD) begin
      for (int k = 0; k < NR; k++) begin
        idx = (m_rr + k) % NR;
        if (g == 2'b00 && req_valid_in[idx]) g[idx] = 1'b1;
      end
    end
    obs_ready = req_ready_out;
    check_val("ready", req_ready_out, g);
    check_val("pending", pending_out, m_q.size());
    check_val("wr_en", wr_en_out, m_out_v);
    if (m_out_v) begin
      check_val("wr_addr", wr_addr_out, m_out[11:4]);
      check_val("wr_data", wr_data_out, m_out[3:0]);
    end
    check_val("flush", frame_flush_out, m_blank_prev && !blank && m_zero_prev);
    m_grant = '0;
    if (!rst_in) begin
      m_zero_prev  = (m_q.size() == 0);
      m_blank_prev = blank;
      m_out_v      = 1'b0;
      if (blank && m_q.size() > 0) begin
        m_out   = m_q.pop_front();
        m_out_v = 1'b1;
      end
      for (int k = 0; k < NR; k++) begin
        if (g[k]) begin
          m_q.push_back({req_addr_in[k*AW +: AW], req_tile_in[k*TW +: TW]});
          m_rr = (k + 1) % NR;
        end
      end
      m_grant = g;
    end
    @(posedge clk_in);
    #1;
    hcount_in = hcount_in + 11'd1;
  endtask

  initial begin
    rst_in = 1'b1; hcount_in = '0; vcount_in = 10'd100;
    req_valid_in = '0; req_addr_in = '0; req_tile_in = '0;
    m_reset();
    cycle(); cycle();
    check_val("rst_pending", pending_out, 0);
    rst_in = 1'b0;
    cycle();

    // Two successive pushes in active video, then drained at blanking start
    set_req(0, 1'b1, 8'h23, 4'h5); cycle();
    set_req(0, 1'b0, 8'h00, 4'h0); set_req(1, 1'b1, 8'h24, 4'h1); cycle();
    set_req(1, 1'b0, 8'h00, 4'h0); cycle();
    check_val("t1_pending", pending_out, 2);
    check_val("t1_nowr", wr_en_out, 0);
    vcount_in = 10'd720; hcount_in = '0; cycle();
    check_val("t1_wr0_en", wr_en_out, 1);
    check_val("t1_wr0_addr", wr_addr_out, 8'h23);
    check_val("t1_wr0_data", wr_data_out, 4'h5);
    cycle();
    check_val("t1_wr1_addr", wr_addr_out, 8'h24);
    check_val("t1_wr1_data", wr_data_out, 4'h1);
    cycle();
    check_val("t1_wr_off", wr_en_out, 0);
    check_val("t1_empty", pending_out, 0);
    vcount_in = 10'd721; cycle();
    vcount_in = 10'd100; #1;
    check_val("t1_flush", frame_flush_out, 1);
    cycle();

    // Both requesters continuously valid: alternating grants until full
    a0 = 8'h40; a1 = 8'h50;
    set_req(0, 1'b1, a0, 4'h6); set_req(1, 1'b1, a1, 4'h7);
    for (int i = 0; i < 4; i++) begin
      cycle();
      check_val("t2_grant", obs_ready, (i % 2 == 0) ? 2'b01 : 2'b10);
      if (m_grant[0]) begin a0 = a0 + 8'd1; set_req(0, 1'b1, a0, 4'h6); end
      if (m_grant[1]) begin a1 = a1 + 8'd1; set_req(1, 1'b1, a1, 4'h7); end
    end
    cycle();
    check_val("t2_full_ready", obs_ready, 2'b00);
    check_val("t2_full_pending", pending_out, 4);

    // Full FIFO with a pop: no ready that cycle, ready the next
    set_req(1, 1'b0, 8'h00, 4'h0);
    vcount_in = 10'd720; cycle();
    check_val("t6_full_pop_ready", obs_ready, 2'b00);
    cycle();
    check_val("t6_next_ready", obs_ready, 2'b01);
    set_req(0, 1'b0, 8'h00, 4'h0);
    for (int i = 0; i < 6; i++) cycle();
    check_val("t6_drained", pending_out, 0);

    // Push during blanking with FIFO empty: write two cycles later
    set_req(0, 1'b1, 8'hFF, 4'hA); cycle();
    set_req(0, 1'b0, 8'h00, 4'h0);
    check_val("t4_nowr_t1", wr_en_out, 0);
    cycle();
    check_val("t4_wr_en", wr_en_out, 1);
    check_val("t4_wr_addr", wr_addr_out, 8'hFF);
    check_val("t4_wr_data", wr_data_out, 4'hA);
    a0 = 8'h80;
    for (int i = 0; i < 5; i++) begin
      set_req(0, 1'b1, a0, 4'h2); cycle();
      check_val("t4_steady", pending_out, 1);
      a0 = a0 + 8'd1;
    end
    set_req(0, 1'b0, 8'h00, 4'h0);
    cycle(); cycle();
    vcount_in = 10'd100; cycle();

    // Four queued entries split across two blanking intervals
    for (int i = 0; i < 4; i++) begin
      set_req(0, 1'b1, 8'h10 + 8'(i), 4'(i + 1)); cycle();
    end
    set_req(0, 1'b0, 8'h00, 4'h0); cycle();
    check_val("t5_full", pending_out, 4);
    vcount_in = 10'd720; cycle();
    vcount_in = 10'd721; cycle();
    vcount_in = 10'd100; #1;
    check_val("t5_noflush", frame_flush_out, 0);
    check_val("t5_left", pending_out, 2);
    cycle(); cycle();
    vcount_in = 10'd720; cycle(); cycle(); cycle();
    vcount_in = 10'd100; #1;
    check_val("t5_flush", frame_flush_out, 1);
    cycle();

    // Mid-operation reset with queued entries and a write in flight
    for (int i = 0; i < 3; i++) begin
      set_req(1, 1'b1, 8'hC0 + 8'(i), 4'hC); cycle();
    end
    set_req(1, 1'b0, 8'h00, 4'h0);
    vcount_in = 10'd720; cycle();
    check_val("rst_pre_wr", wr_en_out, 1);
    rst_in = 1'b1; m_reset(); #1;
    check_val("rst_wr_drop", wr_en_out, 0);
    check_val("rst_clear", pending_out, 0);
    vcount_in = 10'd100; cycle();
    check_val("rst_ready", obs_ready, 2'b00);
    rst_in = 1'b0;
    cycle(); cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
